// File: rtl/lcd_hd44780_responder.sv
// rtl/lcd_hd44780_responder.sv - HD44780 8-bit bus responder with 2x16 DDRAM shadow and busy emulation
module lcd_hd44780_responder #(
    parameter int BUSY_SHORT = 2,
    parameter int BUSY_LONG  = 80
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lcd_e,
    input  logic         lcd_rs,
    input  logic         lcd_rw,
    input  logic [7:0]   lcd_data,
    output logic [7:0]   rd_data,
    output logic [127:0] line1_text,
    output logic [127:0] line2_text,
    output logic [6:0]   cursor_addr,
    output logic         display_on,
    output logic         busy,
    output logic         protocol_err
);

    localparam int             CW    = 16;
    localparam logic [127:0]   BLANK = {16{8'h20}};
    localparam logic [CW-1:0]  N_SHORT = CW'(BUSY_SHORT);
    localparam logic [CW-1:0]  N_LONG  = CW'(BUSY_LONG);

    logic           e_q;
    logic           rs_s_q, rs_s_d;
    logic           rw_s_q, rw_s_d;
    logic [7:0]     data_s_q, data_s_d;
    logic [127:0]   line1_q, line1_d;
    logic [127:0]   line2_q, line2_d;
    logic [6:0]     ac_q, ac_d;
    logic           inc_q, inc_d;
    logic           disp_q, disp_d;
    logic           cgram_q, cgram_d;
    logic           perr_q, perr_d;
    logic [CW-1:0]  busy_cnt_q, busy_cnt_d;
    logic [7:0]     rd_data_q, rd_data_d;

    logic           e_fall;
    logic           e_rise;
    logic           busy_now;
    logic           ac_visible;
    logic [6:0]     bit_idx;
    logic [7:0]     char_at_ac;

    // Two-line address counter step: each line is 40 cells, wrapping line 1 -> line 2 -> line 1.
    // Addresses parked past the end of a line jump to the start of the other line.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
        logic [6:0] nxt;
        if (up) begin
            if (!ac[6] && ac >= 7'h27) begin
                nxt = 7'h40;
            end else if (ac[6] && ac[5:0] >= 6'h27) begin
                nxt = 7'h00;
            end else begin
                nxt = ac + 7'd1;
            end
        end else begin
            if (ac == 7'h00) begin
                nxt = 7'h67;
            end else if (ac == 7'h40) begin
                nxt = 7'h27;
            end else begin
                nxt = ac - 7'd1;
            end
        end
        return nxt;
    endfunction

    assign e_fall     = e_q & ~lcd_e;
    assign e_rise     = ~e_q & lcd_e;
    assign busy_now   = (busy_cnt_q != '0);
    assign ac_visible = (ac_q[5:4] == 2'b00);
    // Column 0 lives in the top byte, so the bit offset is (15 - col) * 8.
    assign bit_idx    = {~ac_q[3:0], 3'b000};
    assign char_at_ac = !ac_visible ? 8'h20 :
                        (ac_q[6] ? line2_q[bit_idx +: 8] : line1_q[bit_idx +: 8]);

    // Transfer decode, DDRAM update, address stepping and busy countdown.
    always_comb begin
        rs_s_d     = rs_s_q;
        rw_s_d     = rw_s_q;
        data_s_d   = data_s_q;
        line1_d    = line1_q;
        line2_d    = line2_q;
        ac_d       = ac_q;
        inc_d      = inc_q;
        disp_d     = disp_q;
        cgram_d    = cgram_q;
        perr_d     = perr_q;
        rd_data_d  = rd_data_q;
        busy_cnt_d = busy_now ? (busy_cnt_q - CW'(1)) : '0;

        // Bus fields are captured while enable is high; the fall uses the last high-cycle values.
        if (lcd_e) begin
            rs_s_d   = lcd_rs;
            rw_s_d   = lcd_rw;
            data_s_d = lcd_data;
        end

        // Read data is presented on the rising edge so it is stable while enable is high.
        if (e_rise && lcd_rw) begin
            rd_data_d = lcd_rs ? char_at_ac : {busy_now, ac_q};
        end

        if (e_fall) begin
            if (busy_now) begin
                perr_d = 1'b1;
            end
            unique case ({rs_s_q, rw_s_q})
                2'b00: begin
                    casez (data_s_q)
                        8'b1???_????: begin
                            ac_d       = data_s_q[6:0];
                            cgram_d    = 1'b0;
                            busy_cnt_d = N_SHORT;
                        end
                        8'b01??_????: begin
                            cgram_d    = 1'b1;
                            busy_cnt_d = N_SHORT;
                        end
                        8'b001?_????: begin
                            busy_cnt_d = N_SHORT;
                        end
                        8'b0001_????: begin
                            if (!data_s_q[3]) begin
                                ac_d = ac_step(ac_q, data_s_q[2]);
                            end
                            busy_cnt_d = N_SHORT;
                        end
                        8'b0000_1???: begin
                            disp_d     = data_s_q[2];
                            busy_cnt_d = N_SHORT;
                        end
                        8'b0000_01??: begin
                            inc_d      = data_s_q[1];
                            busy_cnt_d = N_SHORT;
                        end
                        8'b0000_001?: begin
                            ac_d       = 7'h00;
                            busy_cnt_d = N_LONG;
                        end
                        8'b0000_0001: begin
                            line1_d    = BLANK;
                            line2_d    = BLANK;
                            ac_d       = 7'h00;
                            inc_d      = 1'b1;
                            busy_cnt_d = N_LONG;
                        end
                        default: begin
                            // 0x00 is a no-op and does not touch the busy counter.
                        end
                    endcase
                end
                2'b10: begin
                    if (!cgram_q && ac_visible) begin
                        if (ac_q[6]) begin
                            line2_d[bit_idx +: 8] = data_s_q;
                        end else begin
                            line1_d[bit_idx +: 8] = data_s_q;
                        end
                    end
                    ac_d       = ac_step(ac_q, inc_q);
                    busy_cnt_d = N_SHORT;
                end
                2'b11: begin
                    ac_d = ac_step(ac_q, inc_q);
                end
                default: begin
                    // Status read has no side effect at the fall.
                end
            endcase
        end
    end

    // State registers with synchronous reset; a fall during reset is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q        <= 1'b0;
            rs_s_q     <= 1'b0;
            rw_s_q     <= 1'b0;
            data_s_q   <= 8'h00;
            line1_q    <= BLANK;
            line2_q    <= BLANK;
            ac_q       <= 7'h00;
            inc_q      <= 1'b1;
            disp_q     <= 1'b0;
            cgram_q    <= 1'b0;
            perr_q     <= 1'b0;
            busy_cnt_q <= '0;
            rd_data_q  <= 8'h00;
        end else begin
            e_q        <= lcd_e;
            rs_s_q     <= rs_s_d;
            rw_s_q     <= rw_s_d;
            data_s_q   <= data_s_d;
            line1_q    <= line1_d;
            line2_q    <= line2_d;
            ac_q       <= ac_d;
            inc_q      <= inc_d;
            disp_q     <= disp_d;
            cgram_q    <= cgram_d;
            perr_q     <= perr_d;
            busy_cnt_q <= busy_cnt_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign line1_text   = line1_q;
    assign line2_text   = line2_q;
    assign cursor_addr  = ac_q;
    assign display_on   = disp_q;
    assign busy         = busy_now;
    assign protocol_err = perr_q;

endmodule
